// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - width helper, NaR pattern and stage-1 payload type for posit_field_extract
package posit_pkg;

  localparam int MAX_BITS = 64;
  localparam int MAX_ES   = 8;

  function automatic int scale_width(input int bits, input int es);
    return $clog2(bits) + es + 2;
  endfunction

  localparam int MAX_SCALE_W = scale_width(MAX_BITS, MAX_ES);

  function automatic logic [MAX_BITS-1:0] nar_pattern(input int bits);
    return MAX_BITS'(1) << (bits - 1);
  endfunction

  // Fields are sized for the widest supported posit; narrower builds fill the low bits.
  typedef struct packed {
    logic                   sign;
    logic                   zero;
    logic                   nar;
    logic [MAX_SCALE_W-1:0] seed;
    logic [MAX_ES-1:0]      exp;
    logic [MAX_BITS-1:0]    frac;
  } posit_s1_t;

endpackage

// File: rtl/posit_pipe_stage.sv
// rtl/posit_pipe_stage.sv - one-entry valid/ready payload register
module posit_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/posit_field_extract.sv
// rtl/posit_field_extract.sv - splits exp/frac, forms scale and mantissa; optional POSIT_FIELD_EXTRACT_NAR_STICKY_EN
module posit_field_extract
  import posit_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int ES      = 2,
  parameter int SCALE_W = scale_width(BITS, ES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITS-1:0]           in_raw,
  input  logic [BITS-1:0]           in_seed,
  input  logic [BITS-1:0]           in_shifted,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic signed [SCALE_W-1:0] out_scale,
  output logic [BITS-ES:0]          out_mant,
  output logic                      out_zero,
  output logic                      out_nar
`ifdef POSIT_FIELD_EXTRACT_NAR_STICKY_EN
  ,
  output logic                      nar_sticky,
  input  logic                      nar_clear
`endif
);

  localparam int MW  = BITS - ES + 1;
  localparam int S2W = 3 + SCALE_W + MW;
  localparam logic [BITS-1:0] NAR = BITS'(nar_pattern(BITS));

  posit_s1_t s1_d, s1_q;
  logic      s1_in_ready, s1_valid, s2_in_ready;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_raw[BITS-1];
    s1_d.zero = (in_raw == '0);
    s1_d.nar  = (in_raw == NAR);
    s1_d.seed = MAX_SCALE_W'($signed(in_seed[SCALE_W-1:0]));
    s1_d.exp  = MAX_ES'(in_shifted[BITS-1 -: ES]);
    s1_d.frac = MAX_BITS'(in_shifted[BITS-ES-1:0]);
  end

  // in_ready is held low while reset is asserted so no output reads 1 in reset.
  assign in_ready = s1_in_ready & rst_n;

  posit_pipe_stage #(.W($bits(posit_s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  logic signed [SCALE_W-1:0] seed_s, scale_d;
  logic [MW-1:0]             mant_d;
  logic [S2W-1:0]            s2_d, s2_q;

  always_comb begin
    seed_s  = s1_q.seed[SCALE_W-1:0];
    scale_d = (seed_s <<< ES) + SCALE_W'(s1_q.exp[ES-1:0]);
    mant_d  = {1'b1, s1_q.frac[BITS-ES-1:0]};
    if (s1_q.zero || s1_q.nar) begin
      scale_d = '0;
      mant_d  = '0;
    end
    s2_d = {s1_q.sign, s1_q.zero, s1_q.nar, scale_d, mant_d};
  end

  posit_pipe_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {out_sign, out_zero, out_nar, out_scale, out_mant} = s2_q;

  // Upper seed bits and the max-width padding of the payload carry no information.
  logic unused_bits;
  assign unused_bits = ^{in_seed, s1_q.seed, s1_q.exp, s1_q.frac};

`ifdef POSIT_FIELD_EXTRACT_NAR_STICKY_EN
  logic nar_sticky_q, nar_sticky_d;

  always_comb begin
    nar_sticky_d = nar_sticky_q;
    if (nar_clear) nar_sticky_d = 1'b0;
    if (out_valid && out_ready && out_nar) nar_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nar_sticky_q <= 1'b0;
    else        nar_sticky_q <= nar_sticky_d;
  end

  assign nar_sticky = nar_sticky_q;
`endif

endmodule
